// File: rtl/ngc_fifo_param_if.sv
// ngc_fifo_param_if
//   Bundles the FIFO's control, data and status signals between a user block
//   and the FIFO. The clock and reset are not part of the bundle.
//
//   Signals (direction seen from the FIFO):
//     flush        in   drop all stored words
//     push / din   in   write request and write data
//     pop          in   read request
//     clr_err      in   clear the sticky overflow/underflow flags
//     dout         out  read data
//     dout_valid   out  dout carries a valid word
//     count        out  number of stored words
//     empty, full, almost_empty, almost_full   out  decodes of count
//     overflow, underflow                      out  sticky error flags
//
//   Modports:
//     master  the user block: drives the requests, reads the status
//     slave   the FIFO: reads the requests, drives the status
//
//   Handshake: push and pop are single-cycle requests sampled on each rising
//   edge. There is no back-pressure wait. A request the FIFO cannot honour
//   (push when full and not popping, pop when empty) is dropped and recorded
//   in overflow or underflow.
interface ngc_fifo_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  flush;
   logic                  push;
   logic [DATA_WIDTH-1:0] din;
   logic                  pop;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic [CW-1:0]         count;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, push, din, pop, clr_err,
      input  dout, dout_valid, count, empty, full,
             almost_empty, almost_full, overflow, underflow
   );

   modport slave (
      input  flush, push, din, pop, clr_err,
      output dout, dout_valid, count, empty, full,
             almost_empty, almost_full, overflow, underflow
   );
endinterface

// File: rtl/ngc_fifo_param.sv
// ngc_fifo_param
//   Synchronous single-clock FIFO. The depth can be any value of 2 or more, not
//   only a power of two. The read side is either registered (FWFT=0) or first-word
//   fall-through (FWFT=1). The FIFO also provides almost-full and almost-empty
//   thresholds, a flush input and sticky overflow/underflow flags.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   ngc_fifo_param_if.slave: flush, push/din, pop, clr_err in;
//           dout, dout_valid, count, empty/full/almost_*, overflow/underflow out
//
//   Parameters:
//     DATA_WIDTH     word width
//     DEPTH          number of entries (>= 2)
//     FWFT           0: dout is registered and appears one cycle after the pop
//                    1: dout shows the head word combinationally
//     AFULL_THRESH   almost_full  when count >= AFULL_THRESH
//     AEMPTY_THRESH  almost_empty when count <= AEMPTY_THRESH
module ngc_fifo_param #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 14,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic             clk,
   input  logic             rst,
   ngc_fifo_param_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          underflow_q;

   logic          empty_w;
   logic          full_w;
   logic          pop_ok;
   logic          push_ok;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] wr_ptr_nxt;

   // ------------------------------------------------------------------
   // Status decodes. All of them are derived from the registered count.
   // ------------------------------------------------------------------
   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CW'(DEPTH));

   assign bus.count        = count_q;
   assign bus.empty        = empty_w;
   assign bus.full         = full_w;
   assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
   assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

   // A push into a full FIFO still succeeds when a pop is accepted in the
   // same cycle: the pop frees the slot that the push fills.
   assign pop_ok  = bus.pop && !empty_w;
   assign push_ok = bus.push && (!full_w || pop_ok);

   // The depth need not be a power of two, so the pointers wrap explicitly
   // at DEPTH-1 rather than relying on natural overflow.
   assign rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
   assign wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

   // ------------------------------------------------------------------
   // Storage. Reset does not clear it; only accepted pushes write it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst && !bus.flush && push_ok) begin
         mem[wr_ptr] <= bus.din;
      end
   end

   // ------------------------------------------------------------------
   // Pointers and count
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (pop_ok) begin
            rd_ptr <= rd_ptr_nxt;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr_nxt;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags. A new error in the same cycle as clr_err wins.
   // Requests that arrive during a flush are ignored and never flagged,
   // but clr_err still takes effect during a flush.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.flush) begin
         overflow_q  <= overflow_q  && !bus.clr_err;
         underflow_q <= underflow_q && !bus.clr_err;
      end else begin
         overflow_q  <= (overflow_q  && !bus.clr_err) || (bus.push && !push_ok);
         underflow_q <= (underflow_q && !bus.clr_err) || (bus.pop  && !pop_ok);
      end
   end

   // ------------------------------------------------------------------
   // Read port
   // ------------------------------------------------------------------
   generate
      if (FWFT != 0) begin : g_fwft
         // The head word is visible without a pop. The output is forced to
         // zero while the FIFO is empty, so that the uninitialised storage
         // never reaches dout after reset or a flush.
         assign bus.dout       = empty_w ? '0 : mem[rd_ptr];
         assign bus.dout_valid = !empty_w;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  dout_valid_q;

         // dout_valid is a one-cycle strobe for each accepted pop. dout holds
         // the last word read until the next accepted pop.
         always_ff @(posedge clk) begin
            if (rst) begin
               dout_q       <= '0;
               dout_valid_q <= 1'b0;
            end else if (bus.flush) begin
               dout_valid_q <= 1'b0;
            end else begin
               dout_valid_q <= pop_ok;
               if (pop_ok) begin
                  dout_q <= mem[rd_ptr];
               end
            end
         end

         assign bus.dout       = dout_q;
         assign bus.dout_valid = dout_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_ngc_fifo_param.sv
// tb_ngc_fifo_param
//   Directed test of ngc_fifo_param with DEPTH=5, AFULL_THRESH=4 and
//   AEMPTY_THRESH=1. One instance uses the registered read mode (FWFT=0) and
//   a second instance uses first-word fall-through (FWFT=1).
//   When the stimulus issues a pop it queues the hand-written word that pop
//   should return. A monitor per instance removes and compares those words
//   whenever that instance presents read data.
module tb_ngc_fifo_param;

   localparam int DW = 8;
   localparam int DEPTH = 5;
   localparam int AFT = 4;
   localparam int AET = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] exp_a[$];
   logic [DW-1:0] exp_b[$];

   ngc_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_a ();
   ngc_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_b ();

   ngc_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0),
                    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET))
   u_reg (.clk(clk), .rst(rst), .bus(bus_a));

   ngc_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1),
                    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET))
   u_fwft (.clk(clk), .rst(rst), .bus(bus_b));

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
      $fatal(1, "watchdog");
   end

   // ---------------- compare helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Checks the status outputs of one instance against an expected count and
   // expected error flags. The count decodes follow from the test parameters.
   task automatic check_a(input string tag, input int cnt, input bit ovf, input bit unf);
      check({tag, " count"},        32'(bus_a.count),        32'(cnt));
      check({tag, " empty"},        32'(bus_a.empty),        32'(cnt == 0));
      check({tag, " full"},         32'(bus_a.full),         32'(cnt == DEPTH));
      check({tag, " almost_empty"}, 32'(bus_a.almost_empty), 32'(cnt <= AET));
      check({tag, " almost_full"},  32'(bus_a.almost_full),  32'(cnt >= AFT));
      check({tag, " overflow"},     32'(bus_a.overflow),     32'(ovf));
      check({tag, " underflow"},    32'(bus_a.underflow),    32'(unf));
   endtask

   // ---------------- drivers ----------------
   // Each call presents one cycle of requests, waits for the edge, then
   // returns all requests to idle 1 time unit after the edge.
   task automatic drive_a(input bit ps, input logic [DW-1:0] d, input bit pp,
                          input bit fl, input bit ce);
      bus_a.push = ps; bus_a.din = d; bus_a.pop = pp;
      bus_a.flush = fl; bus_a.clr_err = ce;
      @(posedge clk); #1;
      bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.flush = 1'b0; bus_a.clr_err = 1'b0;
   endtask

   task automatic drive_b(input bit ps, input logic [DW-1:0] d, input bit pp);
      bus_b.push = ps; bus_b.din = d; bus_b.pop = pp;
      bus_b.flush = 1'b0; bus_b.clr_err = 1'b0;
      @(posedge clk); #1;
      bus_b.push = 1'b0; bus_b.pop = 1'b0;
   endtask

   // ---------------- monitors ----------------
   // Registered mode: each cycle in which dout_valid is high delivers one word.
   always @(negedge clk) begin
      if (bus_a.dout_valid) begin
         if (exp_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_a unexpected word: got %0h expected none", bus_a.dout);
         end else begin
            check("mon_a dout", 32'(bus_a.dout), 32'(exp_a.pop_front()));
         end
      end
   end

   // Fall-through mode: the word is consumed in the cycle that pop is high
   // while dout_valid is high.
   always @(negedge clk) begin
      if (bus_b.pop && bus_b.dout_valid) begin
         if (exp_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_b unexpected word: got %0h expected none", bus_b.dout);
         end else begin
            check("mon_b dout", 32'(bus_b.dout), 32'(exp_b.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus_a.push = 0; bus_a.din = '0; bus_a.pop = 0; bus_a.flush = 0; bus_a.clr_err = 0;
      bus_b.push = 0; bus_b.din = '0; bus_b.pop = 0; bus_b.flush = 0; bus_b.clr_err = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check_a("reset", 0, 0, 0);
      check("reset dout", 32'(bus_a.dout), 32'h0);
      check("reset dout_valid", 32'(bus_a.dout_valid), 32'h0);
      check("reset b empty", 32'(bus_b.empty), 32'h1);
      check("reset b dout_valid", 32'(bus_b.dout_valid), 32'h0);

      // 1. Fill to full, then overflow, then drain in order
      for (int i = 0; i < 5; i++) begin
         drive_a(1, 8'h11 + 8'(i), 0, 0, 0);
         check_a($sformatf("t1 push%0d", i), i + 1, 0, 0);
      end
      drive_a(1, 8'h66, 0, 0, 0);
      check_a("t1 overflow push", 5, 1, 0);
      for (int i = 0; i < 5; i++) begin
         exp_a.push_back(8'h11 + 8'(i));
         drive_a(0, '0, 1, 0, 0);
         check_a($sformatf("t1 pop%0d", i), 4 - i, 1, 0);
      end
      drive_a(0, '0, 0, 0, 0);
      check("t1 dout_valid drops", 32'(bus_a.dout_valid), 32'h0);
      check("t1 dout holds", 32'(bus_a.dout), 32'h15);
      drive_a(0, '0, 0, 0, 1);
      check_a("t1 clr_err", 0, 0, 0);

      // 2. Pointer wrap with threshold checks
      for (int i = 0; i < 3; i++) drive_a(1, 8'h01 + 8'(i), 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         exp_a.push_back(8'h01 + 8'(i));
         drive_a(0, '0, 1, 0, 0);
      end
      check_a("t2 after 3/3", 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive_a(1, 8'hA0 + 8'(i), 0, 0, 0);
         check_a($sformatf("t2 push%0d", i), i + 1, 0, 0);
      end
      for (int i = 0; i < 5; i++) begin
         exp_a.push_back(8'hA0 + 8'(i));
         drive_a(0, '0, 1, 0, 0);
         check_a($sformatf("t2 pop%0d", i), 4 - i, 0, 0);
      end

      // 3. Full push+pop, then empty push+pop
      for (int i = 0; i < 5; i++) drive_a(1, 8'hC0 + 8'(i), 0, 0, 0);
      check_a("t3 full", 5, 0, 0);
      exp_a.push_back(8'hC0);
      drive_a(1, 8'hBB, 1, 0, 0);
      check_a("t3 full push+pop", 5, 0, 0);
      exp_a.push_back(8'hC1); exp_a.push_back(8'hC2); exp_a.push_back(8'hC3);
      exp_a.push_back(8'hC4); exp_a.push_back(8'hBB);
      for (int i = 0; i < 5; i++) drive_a(0, '0, 1, 0, 0);
      check_a("t3 drained", 0, 0, 0);
      drive_a(1, 8'h42, 1, 0, 0);
      check_a("t3 empty push+pop", 1, 0, 1);
      exp_a.push_back(8'h42);
      drive_a(0, '0, 1, 0, 0);
      check_a("t3 read 42", 0, 0, 1);
      drive_a(0, '0, 0, 0, 1);
      check_a("t3 clr_err", 0, 0, 0);

      // 5. Flush with push and pop asserted, then clr_err races an error
      for (int i = 0; i < 3; i++) drive_a(1, 8'h31 + 8'(i), 0, 0, 0);
      check_a("t5 filled", 3, 0, 0);
      drive_a(1, 8'h99, 1, 1, 0);
      check_a("t5 flush", 0, 0, 0);
      check("t5 flush dout_valid", 32'(bus_a.dout_valid), 32'h0);
      check("t5 flush dout holds", 32'(bus_a.dout), 32'h42);
      drive_a(0, '0, 1, 0, 1);
      check_a("t5 clr_err+pop empty", 0, 0, 1);
      drive_a(0, '0, 0, 0, 1);
      check_a("t5 clr_err alone", 0, 0, 0);

      // 4. First-word fall-through instance
      drive_b(1, 8'h7E, 0);
      check("t4 b dout", 32'(bus_b.dout), 32'h7E);
      check("t4 b dout_valid", 32'(bus_b.dout_valid), 32'h1);
      check("t4 b count", 32'(bus_b.count), 32'h1);
      exp_b.push_back(8'h7E);
      drive_b(0, '0, 1);
      check("t4 b empty after pop", 32'(bus_b.empty), 32'h1);
      check("t4 b dout_valid after pop", 32'(bus_b.dout_valid), 32'h0);
      drive_b(1, 8'h21, 0);
      drive_b(1, 8'h22, 0);
      exp_b.push_back(8'h21);
      drive_b(0, '0, 1);
      check("t4 b next head", 32'(bus_b.dout), 32'h22);
      check("t4 b count 1", 32'(bus_b.count), 32'h1);
      exp_b.push_back(8'h22);
      drive_b(0, '0, 1);
      check("t4 b underflow clear", 32'(bus_b.underflow), 32'h0);
      drive_b(0, '0, 1);
      check("t4 b underflow on empty pop", 32'(bus_b.underflow), 32'h1);

      // 6. Reset in the middle of traffic, with flush, push and pop all high
      for (int i = 0; i < 3; i++) drive_a(1, 8'h51 + 8'(i), 0, 0, 0);
      exp_a.push_back(8'h51);
      drive_a(0, '0, 1, 0, 0);
      drive_a(1, 8'h54, 0, 0, 0);
      drive_a(1, 8'h55, 0, 0, 0);
      check_a("t6 before rst", 4, 0, 0);
      drive_a(1, 8'h61, 0, 0, 0);
      drive_a(1, 8'h62, 0, 0, 0);
      check_a("t6 overflow before rst", 5, 1, 0);
      rst = 1'b1;
      drive_a(1, 8'hEE, 1, 1, 0);
      rst = 1'b0;
      check_a("t6 after rst", 0, 0, 0);
      check("t6 rst dout", 32'(bus_a.dout), 32'h0);
      check("t6 rst dout_valid", 32'(bus_a.dout_valid), 32'h0);
      check("t6 rst b underflow", 32'(bus_b.underflow), 32'h0);
      drive_a(1, 8'h77, 0, 0, 0);
      exp_a.push_back(8'h77);
      drive_a(0, '0, 1, 0, 0);
      drive_a(0, '0, 0, 0, 0);
      check_a("t6 post-rst traffic", 0, 0, 0);

      // All expected words consumed
      check("exp_a drained", 32'(exp_a.size()), 32'h0);
      check("exp_b drained", 32'(exp_b.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
